// File: rtl/el2_exu_div_noc_arbiter_pkg.sv
// Shared types for the divider NoC arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package el2_exu_div_noc_arbiter_pkg;

    // Operand width of the shared divider on this NoC.
    localparam int DIV_ARB_DATA_W      = 32;
    // Default lost-result watchdog, in cycles.
    localparam int DIV_ARB_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DRAIN = 2'd3
    } div_arb_state_t;

    typedef struct packed {
        logic [DIV_ARB_DATA_W-1:0] dividend;
        logic [DIV_ARB_DATA_W-1:0] divisor;
        logic                      is_signed;
        logic                      rem;
    } div_op_t;

endpackage

// File: rtl/el2_exu_div_noc_arbiter_if.sv
// Bundle of requester, divider-send, divider-result and response signals.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready toward requesters, div_valid/div_ready toward the divider.
interface el2_exu_div_noc_arbiter_if
    import el2_exu_div_noc_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DIV_ARB_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_dividend;
    logic [NUM_REQ*DATA_W-1:0] req_divisor;
    logic [NUM_REQ-1:0]        req_signed;
    logic [NUM_REQ-1:0]        req_rem;
    logic [NUM_REQ-1:0]        flush;

    logic                      div_valid;
    logic                      div_ready;
    logic [DATA_W-1:0]         div_dividend;
    logic [DATA_W-1:0]         div_divisor;
    logic                      div_signed;
    logic                      div_rem;

    logic                      res_valid;
    logic [DATA_W-1:0]         res_data;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;

    // Arbiter side.
    modport slave (
        input  req_valid, req_dividend, req_divisor, req_signed, req_rem, flush,
        input  div_ready, res_valid, res_data,
        output req_ready, div_valid, div_dividend, div_divisor, div_signed, div_rem,
        output rsp_valid, rsp_data, rsp_err
    );

    // Requesters and divider side.
    modport master (
        output req_valid, req_dividend, req_divisor, req_signed, req_rem, flush,
        output div_ready, res_valid, res_data,
        input  req_ready, div_valid, div_dividend, div_divisor, div_signed, div_rem,
        input  rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/el2_exu_div_noc_arbiter_rr.sv
// Round-robin picker: grants the first requesting index strictly after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller decides when to advance ptr.
module el2_rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    // Scan ptr+1 .. ptr+N (mod N); ptr itself is checked last so it has lowest priority.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/el2_exu_div_noc_arbiter.sv
// Shares one NoC divider among NUM_REQ requesters, one op in flight, with flush and lost-result watchdog.
// Latency: accept->div_valid 1 cycle; res_valid->rsp_valid 0 cycles; next accept the cycle after rsp.
// Backpressure: req_ready only in IDLE; op held on div_* until div_ready; results never backpressured.
module el2_exu_div_noc_arbiter
    import el2_exu_div_noc_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DIV_ARB_DATA_W,
    parameter int TIMEOUT = DIV_ARB_TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    el2_exu_div_noc_arbiter_if.slave   bus,
    output logic                       busy,
    output logic                       spurious
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    // The latched op record is shared with the rest of the NoC slice, so its width is fixed there.
    if (DATA_W != DIV_ARB_DATA_W) begin : g_width_check
        $error("DATA_W must equal DIV_ARB_DATA_W");
    end

    div_arb_state_t     state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // The rr pointer always equals the last winner, which is also the current owner.
    logic [PW-1:0]      owner_q;
    div_op_t            op_q;
    logic               spurious_q;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt;
    logic               grant_any;
    logic [PW-1:0]      win_idx;
    div_op_t            win_op;
    logic [NUM_REQ-1:0] owner_oh;
    logic               own_flush;
    logic               timeout_hit;

    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [DATA_W-1:0]  rsp_data;
    logic               rsp_err;

    assign eligible    = bus.req_valid & ~bus.flush;
    assign grant_any   = |gnt;
    assign owner_oh    = NUM_REQ'(1) << owner_q;
    assign own_flush   = bus.flush[owner_q];
    assign timeout_hit = (cnt_q == CW'(TIMEOUT-1));

    el2_rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req (eligible),
        .ptr (owner_q),
        .gnt (gnt)
    );

    // Encode the one-hot winner and mux its operands.
    always_comb begin
        win_idx = '0;
        win_op  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_idx          = PW'(i);
                win_op.dividend  = bus.req_dividend[i*DATA_W +: DATA_W];
                win_op.divisor   = bus.req_divisor[i*DATA_W +: DATA_W];
                win_op.is_signed = bus.req_signed[i];
                win_op.rem       = bus.req_rem[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and watchdog counter; an op already accepted by the divider must be drained, not dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (grant_any) begin
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (bus.div_ready) begin
                    state_d = own_flush ? ARB_DRAIN : ARB_WAIT;
                    cnt_d   = '0;
                end else if (own_flush) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.res_valid) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end else if (own_flush || timeout_hit) begin
                    state_d = ARB_DRAIN;
                    cnt_d   = '0;
                end
            end
            ARB_DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.res_valid || timeout_hit) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from registered state; a flushed owner never sees a response.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        if (state_q == ARB_IDLE && !rst) begin
            req_ready = gnt;
        end
        if (state_q == ARB_WAIT && !own_flush) begin
            if (bus.res_valid) begin
                rsp_valid = owner_oh;
                rsp_data  = bus.res_data;
            end else if (timeout_hit) begin
                rsp_valid = owner_oh;
                rsp_err   = 1'b1;
            end
        end
    end

    // Datapath: counter, owner/rr pointer, latched op, sticky spurious-result flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            owner_q    <= PW'(NUM_REQ-1);
            op_q       <= '0;
            spurious_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == ARB_IDLE && grant_any) begin
                owner_q <= win_idx;
                op_q    <= win_op;
            end
            if (bus.res_valid && (state_q == ARB_IDLE || state_q == ARB_ISSUE)) begin
                spurious_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.div_valid    = (state_q == ARB_ISSUE);
    assign bus.div_dividend = op_q.dividend;
    assign bus.div_divisor  = op_q.divisor;
    assign bus.div_signed   = op_q.is_signed;
    assign bus.div_rem      = op_q.rem;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_data     = rsp_data;
    assign bus.rsp_err      = rsp_err;
    assign busy             = (state_q != ARB_IDLE);
    assign spurious         = spurious_q;

endmodule

// File: doc/el2_exu_div_noc_arbiter.md
Name: el2_exu_div_noc_arbiter

Overview:
- Shares one NoC-attached divider between NUM_REQ requesters, e.g. core EXU pipe and a debug/test requester.
- Accepts divide requests, issues exactly one outstanding operation to the divider's NoC send path, and waits for the result from the divider receiver (finish_dly/out).
- Returns the result to the owning requester.
- Handles flush of the owner and lost-result timeout so the divider is never double-booked.

Parameters:
- NUM_REQ, 2, number of requesters (>=2)
- DATA_W, 32, operand/result width
- TIMEOUT, 64, max cycles in WAIT/DRAIN before abandoning (>=2)

Ports:
- clk  in  1  NoC clock (same clock as the divider receiver)
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot accept pulse; transfer = req_valid&req_ready
- req_dividend  in  NUM_REQ*DATA_W  packed, requester i at [i*DATA_W +: DATA_W]
- req_divisor  in  NUM_REQ*DATA_W  packed as above
- req_signed  in  NUM_REQ  signed op
- req_rem  in  NUM_REQ  remainder (1) / quotient (0)
- flush  in  NUM_REQ  per-requester kill of its pending/queued op
- div_valid  out  1  operation valid toward divider NoC sender
- div_ready  in  1  sender accepted operation
- div_dividend  out  DATA_W  latched operand
- div_divisor  out  DATA_W  latched operand
- div_signed  out  1  latched
- div_rem  out  1  latched
- res_valid  in  1  result strobe (divider receiver finish_dly)
- res_data  in  DATA_W  result (divider receiver out)
- rsp_valid  out  NUM_REQ  one-cycle one-hot response strobe
- rsp_data  out  DATA_W  response data, valid with rsp_valid
- rsp_err  out  1  response is a timeout, data = 0
- busy  out  1  state != IDLE
- spurious  out  1  sticky: res_valid seen in IDLE or ISSUE

Behaviour:
- Reset: state=IDLE, rr pointer=NUM_REQ-1, all outputs 0, latched operands 0, counter 0, spurious=0.
- States IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - eligible = req_valid & ~flush.
  - If any bit is eligible, round-robin picks the first eligible index after the rr pointer. req_ready[winner]=1 combinationally in that cycle.
  - Operands and owner are latched, the rr pointer is updated to the winner, and state goes to ISSUE.
  - Requesters that are not picked see req_ready=0.
- ISSUE:
  - div_valid=1, outputs driven from registers and held stable until div_ready.
  - div_ready=1 moves to WAIT and clears the counter.
  - flush[owner]=1 (even with div_ready low) drops the op, goes to IDLE, no rsp.
  - If flush and div_ready are both high in the same cycle, the op is already sent and the result goes to DRAIN.
- WAIT:
  - The counter increments each cycle.
  - res_valid: rsp_valid[owner]=1, rsp_data=res_data, rsp_err=0 for one cycle, then IDLE.
  - flush[owner] without res_valid goes to DRAIN and clears the counter. If flush and res_valid are both high, the result is discarded with no rsp and the state goes to IDLE.
  - Counter == TIMEOUT-1 without res_valid: rsp_valid[owner]=1, rsp_err=1, rsp_data=0, go to DRAIN, counter cleared.
- DRAIN:
  - The next res_valid is swallowed silently, then IDLE.
  - Counter == TIMEOUT-1 goes to IDLE with no rsp.
- res_valid in IDLE/ISSUE is ignored and sets spurious. Only rst clears spurious.
- Latency: request accept to div_valid = 1 cycle. res_valid to rsp_valid = 0 cycles (combinational from registered state). Back-to-back: a new request is accepted the cycle after rsp.
- Reset mid-operation returns to IDLE immediately. A result arriving later sets spurious.

Decomposition:
- In noc_types: typedef enum for div_arb_state_t, struct div_op_t {dividend, divisor, signed, rem}, localparam DIV_ARB_TIMEOUT_DEF.
- One sub-module: el2_rr_arbiter (parameter N; inputs req and ptr; output one-hot gnt), reusable for other shared NoC units.

Test Plan:
- Single op: req0 100/7 quotient, div_ready after 2 cycles, res_valid with 14 five cycles later -> rsp_valid=01, rsp_data=14, rsp_err=0, busy falls the next cycle.
- Contention: req0 and req1 both valid continuously -> grants alternate 0,1,0,1. With ptr reset to 1, the first grant goes to 0. Each rsp goes to the correct owner.
- Flush in ISSUE: req1 accepted, flush[1] while div_ready=0 -> IDLE, no rsp, div_valid drops the next cycle, req0 is granted next.
- Flush in WAIT: after issue, flush[0], then res_valid with 0xDEAD -> no rsp_valid, state DRAIN->IDLE, spurious=0.
- Timeout: TIMEOUT=8, no res_valid -> on the 8th WAIT cycle rsp_valid=01, rsp_err=1, rsp_data=0. A late res_valid 3 cycles later is swallowed. If it never arrives, IDLE after 8 more cycles.
- Spurious/reset: res_valid in IDLE -> spurious=1 and stays 1. rst asserted mid-WAIT -> all outputs 0 asynchronously, state IDLE.
